// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and width defaults for the memory arbiter
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPU = 2'd1,
    OWN_DBG = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DBG = 1'b1
  } port_id_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - one requester port of the memory arbiter (CPU or debug loader)
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rdata, rvalid
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rdata, rvalid
  );

endinterface

// File: rtl/mem_arb_port_mux.sv
// rtl/mem_arb_port_mux.sv - steers the granted port's address/data/we onto the memory bus
module mem_arb_port_mux
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              gnt_valid,
  input  port_id_e          owner,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_acc,
  output logic              mem_read,
  output logic              mem_write
);

  // The bus is held at zero whenever nobody is granted.
  always_comb begin
    mem_address = '0;
    mem_acc     = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    if (gnt_valid) begin
      if (owner == PORT_CPU) begin
        mem_address = cpu_addr;
        mem_acc     = cpu_wdata;
        mem_write   = cpu_we;
        mem_read    = !cpu_we;
      end else begin
        mem_address = dbg_addr;
        mem_acc     = dbg_wdata;
        mem_write   = dbg_we;
        mem_read    = !dbg_we;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/debug arbiter for a shared data memory
// MEM_ARB_ROUND_ROBIN_EN selects round-robin with HOLD_MAX fairness; default is fixed CPU priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      cpu,
  mem_arbiter_if.slave      dbg,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_acc,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_data
);

  localparam int HOLD_W = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);

  arb_state_e        state_q, state_d;
  port_id_e          last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              dbg_rvalid_q, dbg_rvalid_d;

  logic cpu_gnt, dbg_gnt;
  logic cpu_yield, dbg_yield, tie_cpu;

  // Reset gates the grants so nothing reaches the memory while rst is high.
  assign cpu_gnt = !rst && (state_q == OWN_CPU) && cpu.req;
  assign dbg_gnt = !rst && (state_q == OWN_DBG) && dbg.req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
  assign cpu_yield = dbg.req && (hold_q >= HOLD_LAST);
  assign dbg_yield = cpu.req && (hold_q >= HOLD_LAST);
  assign tie_cpu   = (last_q == PORT_DBG);
`else
  assign cpu_yield = 1'b0;
  assign dbg_yield = cpu.req;
  assign tie_cpu   = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cpu.req && dbg.req) state_d = tie_cpu ? OWN_CPU : OWN_DBG;
        else if (cpu.req)       state_d = OWN_CPU;
        else if (dbg.req)       state_d = OWN_DBG;
      end
      OWN_CPU: begin
        if (cpu.req && !cpu_yield) state_d = OWN_CPU;
        else if (dbg.req)          state_d = OWN_DBG;
        else                       state_d = IDLE;
      end
      OWN_DBG: begin
        if (dbg.req && !dbg_yield) state_d = OWN_DBG;
        else if (cpu.req)          state_d = OWN_CPU;
        else                       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Hold count tracks contested grants to the current owner; saturates at HOLD_MAX.
  always_comb begin
    hold_d = '0;
    if (((cpu_gnt && dbg.req) || (dbg_gnt && cpu.req)) && (state_d == state_q)) begin
      hold_d = (hold_q < HOLD_LIM) ? hold_q + HOLD_W'(1) : hold_q;
    end
  end

  always_comb begin
    last_d       = last_q;
    if (cpu_gnt)      last_d = PORT_CPU;
    else if (dbg_gnt) last_d = PORT_DBG;
    cpu_rvalid_d = cpu_gnt && !cpu.we;
    dbg_rvalid_d = dbg_gnt && !dbg.we;
    cpu_rdata_d  = cpu_rvalid_d ? mem_data : cpu_rdata_q;
    dbg_rdata_d  = dbg_rvalid_d ? mem_data : dbg_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= PORT_DBG;
      hold_q       <= '0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      hold_q       <= hold_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
    end
  end

  assign cpu.gnt    = cpu_gnt;
  assign cpu.rdata  = cpu_rdata_q;
  assign cpu.rvalid = cpu_rvalid_q;
  assign dbg.gnt    = dbg_gnt;
  assign dbg.rdata  = dbg_rdata_q;
  assign dbg.rvalid = dbg_rvalid_q;

  mem_arb_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_port_mux (
    .gnt_valid   (cpu_gnt || dbg_gnt),
    .owner       (cpu_gnt ? PORT_CPU : PORT_DBG),
    .cpu_we      (cpu.we),
    .cpu_addr    (cpu.addr),
    .cpu_wdata   (cpu.wdata),
    .dbg_we      (dbg.we),
    .dbg_addr    (dbg.addr),
    .dbg_wdata   (dbg.wdata),
    .mem_address (mem_address),
    .mem_acc     (mem_acc),
    .mem_read    (mem_read),
    .mem_write   (mem_write)
  );

endmodule
